// File: rtl/truth_table_pkg.sv
// Shared types and defaults for the truth_table sweep/check stage.
package truth_table_pkg;

  // Sweep controller states.
  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } sweep_state_t;

  localparam int         TT_N_IN_DEFAULT = 3;
  localparam logic [7:0] TT_REF_DEFAULT  = 8'h36;

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
// load_i preloads SETTLE_CYCLES-1; zero_o marks the last settle cycle.
module tt_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic aresetn,
  input  logic load_i,
  output logic zero_o
);

  localparam int            W        = $clog2(SETTLE_CYCLES + 1);
  localparam logic [W-1:0]  LOAD_VAL = W'(SETTLE_CYCLES - 1);

  logic [W-1:0] cnt;

  // Count down from the preload value and park at zero.
  // NOTE: the asynchronous reset is part of the sensitivity list so the counter
  // clears without a clock; all sequential state uses non-blocking assignments.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= LOAD_VAL;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks every input vector of a combinational truth_table block in ascending
// order, compares its output against REF_TABLE and accumulates the results.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int                  N_IN          = TT_N_IN_DEFAULT,
  parameter logic [2**N_IN-1:0]  REF_TABLE     = TT_REF_DEFAULT,
  parameter int                  SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [N_IN-1:0]      vec_o,
  input  logic                 res_i,
  output logic                 err_valid_o,
  output logic [N_IN-1:0]      err_vec_o,
  output logic [N_IN:0]        err_cnt_o,
  output logic [2**N_IN-1:0]   err_map_o
);

  localparam logic [N_IN-1:0] VEC_LAST = '1;

  sweep_state_t state, state_nxt;
  logic         timer_load;
  logic         timer_zero;
  logic         last_vec;
  logic         mismatch;

  tt_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk    (clk),
    .aresetn(aresetn),
    .load_i (timer_load),
    .zero_o (timer_zero)
  );

  assign last_vec = (vec_o == VEC_LAST);
  // The DUT is combinational, so res_i is only meaningful in CHECK.
  assign mismatch = (state == CHECK) && (res_i != REF_TABLE[vec_o]);
  assign busy_o   = (state != IDLE);
  assign done_o   = (state == DONE);

  // State register.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and settle-timer preload.
  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_nxt  = SETTLE;
          timer_load = 1'b1;
        end
      end
      SETTLE: begin
        if (timer_zero) begin
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (last_vec) begin
          state_nxt = DONE;
        end else begin
          state_nxt  = SETTLE;
          timer_load = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Vector register and error bookkeeping; results hold until the next start.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      vec_o       <= '0;
      err_valid_o <= 1'b0;
      err_vec_o   <= '0;
      err_cnt_o   <= '0;
      err_map_o   <= '0;
    end else begin
      err_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            vec_o     <= '0;
            err_cnt_o <= '0;
            err_map_o <= '0;
          end
        end
        CHECK: begin
          if (mismatch) begin
            err_cnt_o        <= err_cnt_o + 1'b1;
            err_map_o[vec_o] <= 1'b1;
            err_vec_o        <= vec_o;
            err_valid_o      <= 1'b1;
          end
          // The last vector leaves through DONE, so the increment never wraps.
          if (!last_vec) begin
            vec_o <= vec_o + 1'b1;
          end
        end
        DONE: begin
          vec_o <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE_CYCLES 1 and 3), each
// driven by a table-lookup truth_table model, checked against expectations
// derived from the mismatch set between the model table and the reference table.
module tb_truth_table_sweeper;

  localparam logic [7:0] REF = 8'h36;

  logic             clk;
  logic             aresetn;
  logic [1:0]       start;
  logic [1:0][7:0]  model;
  logic [1:0]       res;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0][2:0]  vec;
  logic [1:0]       err_valid;
  logic [1:0][2:0]  err_vec;
  logic [1:0][3:0]  err_cnt;
  logic [1:0][7:0]  err_map;

  int compared   = 0;
  int mismatched = 0;
  logic [2:0] last_err_vec [2];

  // Behavioural truth_table blocks: r is the model table bit addressed by {a,b,c}.
  assign res[0] = model[0][vec[0]];
  assign res[1] = model[1][vec[1]];

  truth_table_sweeper #(.N_IN(3), .REF_TABLE(REF), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .aresetn(aresetn), .start_i(start[0]), .busy_o(busy[0]),
    .done_o(done[0]), .vec_o(vec[0]), .res_i(res[0]), .err_valid_o(err_valid[0]),
    .err_vec_o(err_vec[0]), .err_cnt_o(err_cnt[0]), .err_map_o(err_map[0])
  );

  truth_table_sweeper #(.N_IN(3), .REF_TABLE(REF), .SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .aresetn(aresetn), .start_i(start[1]), .busy_o(busy[1]),
    .done_o(done[1]), .vec_o(vec[1]), .res_i(res[1]), .err_valid_o(err_valid[1]),
    .err_vec_o(err_vec[1]), .err_cnt_o(err_cnt[1]), .err_map_o(err_map[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 2; s++) begin
      check($sformatf("%s[%0d] busy", tag, s), 32'(busy[s]), 0);
      check($sformatf("%s[%0d] done", tag, s), 32'(done[s]), 0);
      check($sformatf("%s[%0d] vec", tag, s), 32'(vec[s]), 0);
      check($sformatf("%s[%0d] err_valid", tag, s), 32'(err_valid[s]), 0);
      check($sformatf("%s[%0d] err_vec", tag, s), 32'(err_vec[s]), 0);
      check($sformatf("%s[%0d] err_cnt", tag, s), 32'(err_cnt[s]), 0);
      check($sformatf("%s[%0d] err_map", tag, s), 32'(err_map[s]), 0);
    end
  endtask

  // One full sweep on instance sel with truth table mdl; optionally re-pulses
  // start at cycle poke_at (counted from the accepting edge) to prove it is ignored.
  task automatic run_sweep(input int sel, input logic [7:0] mdl, input int poke_at,
                           input string tag);
    int         per   = (sel == 1) ? 4 : 2;    // settle cycles + one check cycle
    int         total = 8 * per;
    logic [7:0] mism  = mdl ^ REF;
    int         n     = 0;
    bit         done_seen = 0;
    int         exp_vec;
    bit         exp_ev;
    model[sel] = mdl;
    @(negedge clk);
    start[sel] = 1'b1;
    @(negedge clk);                           // edge 0 has accepted the start
    start[sel] = 1'b0;
    while (!done_seen && n <= total + 4) begin
      start[sel] = (n == poke_at) ? 1'b1 : 1'b0;
      exp_vec = (n / per > 7) ? 7 : n / per;
      exp_ev  = (n > 0) && (n % per == 0) && mism[n / per - 1];
      check($sformatf("%s busy n=%0d", tag, n), 32'(busy[sel]), 1);
      check($sformatf("%s vec n=%0d", tag, n), 32'(vec[sel]), 32'(exp_vec));
      check($sformatf("%s err_valid n=%0d", tag, n), 32'(err_valid[sel]), 32'(exp_ev));
      if (exp_ev)
        check($sformatf("%s err_vec n=%0d", tag, n), 32'(err_vec[sel]), 32'(n / per - 1));
      check($sformatf("%s done n=%0d", tag, n), 32'(done[sel]), 32'(n == total));
      if (done[sel]) begin
        done_seen = 1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    start[sel] = 1'b0;
    check($sformatf("%s done latency", tag), 32'(n), 32'(total));
    for (int i = 0; i < 8; i++)
      if (mism[i]) last_err_vec[sel] = 3'(i);
    check($sformatf("%s err_cnt", tag), 32'(err_cnt[sel]), 32'($countones(mism)));
    check($sformatf("%s err_map", tag), 32'(err_map[sel]), 32'(mism));
    check($sformatf("%s err_vec", tag), 32'(err_vec[sel]), 32'(last_err_vec[sel]));
    @(negedge clk);
    check($sformatf("%s idle busy", tag), 32'(busy[sel]), 0);
    check($sformatf("%s idle done", tag), 32'(done[sel]), 0);
    check($sformatf("%s idle vec", tag), 32'(vec[sel]), 0);
    repeat (3) @(negedge clk);
    check($sformatf("%s no second done", tag), 32'(done[sel]), 0);
    check($sformatf("%s hold err_cnt", tag), 32'(err_cnt[sel]), 32'($countones(mism)));
    check($sformatf("%s hold err_map", tag), 32'(err_map[sel]), 32'(mism));
  endtask

  initial begin
    int  waited;
    logic [7:0] rnd;
    aresetn = 1'b0;
    start   = '0;
    model[0] = REF;
    model[1] = REF;
    last_err_vec[0] = '0;
    last_err_vec[1] = '0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    aresetn = 1'b1;

    run_sweep(0, REF, -1, "clean");
    run_sweep(0, REF ^ 8'h40, -1, "inv110");
    run_sweep(0, 8'h00, -1, "stuck0");
    run_sweep(0, REF, 6, "restart_ignored");

    // Asynchronous reset mid-sweep while vector 011 is being driven.
    model[0] = REF;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    waited = 0;
    while (vec[0] != 3'b011 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("midreset reached vec 011", 32'(vec[0]), 32'h3);
    #2 aresetn = 1'b0;
    #1 check_all_zero("midreset");
    last_err_vec[0] = '0;
    last_err_vec[1] = '0;
    @(negedge clk);
    aresetn = 1'b1;
    run_sweep(0, REF, -1, "after_reset");

    for (int k = 0; k < 3; k++) begin
      rnd = 8'($urandom);
      run_sweep(0, rnd, (k == 1) ? int'($urandom_range(1, 14)) : -1,
                $sformatf("rand1_%0d", k));
    end

    run_sweep(1, REF, -1, "settle3_clean");
    run_sweep(1, 8'hFF, -1, "settle3_stuck1");
    for (int k = 0; k < 2; k++) begin
      rnd = 8'($urandom);
      run_sweep(1, rnd, int'($urandom_range(1, 30)), $sformatf("rand3_%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
